// File: rtl/mprj_checkpoint_monitor.sv
// Ordered checkpoint monitor: watches ckpt_in for a sequence of expected values with an optional run timeout.
// Define CKPT_DEGLITCH_EN to require two consecutive equal WAIT cycles per match.
module mprj_checkpoint_monitor #(
    parameter int WIDTH    = 16,
    parameter int NUM_CKPT = 2,
    parameter int TMO_W    = 24,
    localparam int IDX_W   = $clog2(NUM_CKPT + 1)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start,
    input  logic                      clear,
    input  logic [WIDTH-1:0]          ckpt_in,
    input  logic [NUM_CKPT*WIDTH-1:0] ckpt_vals,
    input  logic [TMO_W-1:0]          timeout_cycles,
    output logic                      busy,
    output logic                      pass,
    output logic                      fail,
    output logic [IDX_W-1:0]          ckpt_idx,
    output logic                      match_stb,
    output logic [TMO_W-1:0]          elapsed
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx_nxt, idx_inc;
    logic [TMO_W-1:0] el_nxt;
    logic [TMO_W:0]   el_inc;
    logic [WIDTH-1:0] exp_val;
    logic             stb_nxt, eq, hit, timed;

    // Only the checkpoint currently due is ever compared.
    always_comb begin
        exp_val = '0;
        for (int k = 0; k < NUM_CKPT; k++)
            if (ckpt_idx == IDX_W'(k)) exp_val = ckpt_vals[k*WIDTH +: WIDTH];
    end

    assign eq      = (ckpt_in == exp_val);
    assign idx_inc = ckpt_idx + IDX_W'(1);
    // One extra bit so a saturated counter can never alias onto the limit.
    assign el_inc  = {1'b0, elapsed} + (TMO_W+1)'(1);
    assign timed   = (|timeout_cycles) && (el_inc == {1'b0, timeout_cycles});

`ifdef CKPT_DEGLITCH_EN
    logic seen, seen_nxt;
    assign hit = eq && seen;
`else
    assign hit = eq;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = ckpt_idx;
        el_nxt    = elapsed;
        stb_nxt   = 1'b0;
`ifdef CKPT_DEGLITCH_EN
        seen_nxt  = seen;
`endif
        if (start && state != S_WAIT) begin
            state_nxt = S_WAIT;
            idx_nxt   = '0;
            el_nxt    = '0;
`ifdef CKPT_DEGLITCH_EN
            seen_nxt  = 1'b0;
`endif
        end else begin
            case (state)
                S_WAIT: begin
                    if (!el_inc[TMO_W]) el_nxt = el_inc[TMO_W-1:0];
`ifdef CKPT_DEGLITCH_EN
                    seen_nxt = eq && !hit;
`endif
                    // A match wins over a timeout landing in the same cycle.
                    if (hit) begin
                        idx_nxt = idx_inc;
                        stb_nxt = 1'b1;
                        if (idx_inc == IDX_W'(NUM_CKPT)) state_nxt = S_PASS;
                    end else if (timed) begin
                        state_nxt = S_FAIL;
                    end
                end
                S_PASS, S_FAIL: if (clear) state_nxt = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            ckpt_idx  <= '0;
            elapsed   <= '0;
            match_stb <= 1'b0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
`ifdef CKPT_DEGLITCH_EN
            seen      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ckpt_idx  <= idx_nxt;
            elapsed   <= el_nxt;
            match_stb <= stb_nxt;
            busy      <= (state_nxt == S_WAIT);
            pass      <= (state_nxt == S_PASS);
            fail      <= (state_nxt == S_FAIL);
`ifdef CKPT_DEGLITCH_EN
            seen      <= seen_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Bench for mprj_checkpoint_monitor: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mprj_checkpoint_monitor;
    localparam int WIDTH    = 16;
    localparam int NUM_CKPT = 2;
    localparam int TMO_W    = 12;
    localparam int IDX_W    = $clog2(NUM_CKPT + 1);
    localparam int VW       = 4 + IDX_W + TMO_W;
    localparam int MAX_EL   = (1 << TMO_W) - 1;
`ifdef CKPT_DEGLITCH_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif
    localparam int M_IDLE = 0, M_WAIT = 1, M_PASS = 2, M_FAIL = 3;
    localparam logic [15:0] V60 = 16'hAB60, V61 = 16'hAB61;

    logic                      wb_clk_i, wb_rst_i, start, clear;
    logic [WIDTH-1:0]          ckpt_in;
    logic [NUM_CKPT*WIDTH-1:0] ckpt_vals;
    logic [TMO_W-1:0]          timeout_cycles;
    logic                      busy, pass, fail, match_stb;
    logic [IDX_W-1:0]          ckpt_idx;
    logic [TMO_W-1:0]          elapsed;
    logic [VW-1:0]             dut_vec;

    int errors = 0, checks = 0;
    int m_st, m_idx, m_el, m_stb, m_streak;

    mprj_checkpoint_monitor #(.WIDTH(WIDTH), .NUM_CKPT(NUM_CKPT), .TMO_W(TMO_W)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .clear(clear),
        .ckpt_in(ckpt_in), .ckpt_vals(ckpt_vals), .timeout_cycles(timeout_cycles),
        .busy(busy), .pass(pass), .fail(fail), .ckpt_idx(ckpt_idx),
        .match_stb(match_stb), .elapsed(elapsed)
    );

    assign dut_vec = {busy, pass, fail, match_stb, ckpt_idx, elapsed};

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [VW-1:0] mdl_vec();
        return {m_st == M_WAIT, m_st == M_PASS, m_st == M_FAIL, m_stb != 0,
                IDX_W'(m_idx), TMO_W'(m_el)};
    endfunction

    // Advance the model by one clock using the inputs currently applied, then let the DUT clock.
    task automatic cyc();
        logic eq, hit, timed;
        if (wb_rst_i) begin
            m_st = M_IDLE; m_idx = 0; m_el = 0; m_stb = 0; m_streak = 0;
        end else begin
            m_stb = 0;
            if (start && m_st != M_WAIT) begin
                m_st = M_WAIT; m_idx = 0; m_el = 0; m_streak = 0;
            end else if (clear && (m_st == M_PASS || m_st == M_FAIL)) begin
                m_st = M_IDLE;
            end else if (m_st == M_WAIT) begin
                eq = (ckpt_in == ckpt_vals[m_idx*WIDTH +: WIDTH]);
                hit = eq && (m_streak + 1 >= NEED);
                m_streak = (eq && !hit) ? m_streak + 1 : 0;
                timed = (timeout_cycles != 0) && (m_el + 1 == int'(timeout_cycles));
                if (m_el < MAX_EL) m_el++;
                if (hit) begin
                    m_idx++; m_stb = 1;
                    if (m_idx == NUM_CKPT) m_st = M_PASS;
                end else if (timed) m_st = M_FAIL;
            end
        end
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_reset();
        wb_rst_i = 1; start = 0; clear = 0; ckpt_in = '0; timeout_cycles = '0;
        ckpt_vals = {V61, V60};
        cyc(); cyc();
        checks++;
        if (dut_vec !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", dut_vec); end
        wb_rst_i = 0; cyc();
        checks++;
        if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL reset_idle: got %h want %h", dut_vec, mdl_vec()); end
    endtask

    task automatic test_basic();
        int nstb = 0;
        ckpt_vals = {V61, V60}; timeout_cycles = 1000; ckpt_in = '0;
        start = 1; cyc(); start = 0;
        for (int i = 1; i <= 14; i++) begin
            ckpt_in = (i >= 5 && i < 5 + NEED) ? V60 : (i >= 9 && i < 9 + NEED) ? V61 : 16'h0;
            cyc();
            nstb += int'(match_stb);
            checks++;
            if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL basic cyc%0d: got %h want %h", i, dut_vec, mdl_vec()); end
        end
        checks++;
        if (pass !== 1'b1 || ckpt_idx !== IDX_W'(2) || nstb != 2) begin
            errors++; $display("FAIL basic_end: pass=%b idx=%0d stb=%0d want 1/2/2", pass, ckpt_idx, nstb);
        end
        clear = 1; cyc(); clear = 0;
        checks++;
        if (dut_vec !== mdl_vec() || pass !== 1'b0) begin errors++; $display("FAIL basic_clear: got %h want %h", dut_vec, mdl_vec()); end
    endtask

    task automatic test_timeout();
        ckpt_in = '0; timeout_cycles = 50;
        start = 1; cyc(); start = 0;
        for (int i = 1; i <= 55; i++) begin
            cyc();
            checks++;
            if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL timeout cyc%0d: got %h want %h", i, dut_vec, mdl_vec()); end
        end
        checks++;
        if (fail !== 1'b1 || elapsed !== TMO_W'(50) || ckpt_idx !== '0) begin
            errors++; $display("FAIL timeout_end: fail=%b el=%0d idx=%0d want 1/50/0", fail, elapsed, ckpt_idx);
        end
        start = 1; cyc(); start = 0;
        checks++;
        if (elapsed !== '0 || busy !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL fail_restart: el=%0d busy=%b fail=%b want 0/1/0", elapsed, busy, fail);
        end
        wb_rst_i = 1; cyc(); wb_rst_i = 0;
    endtask

    task automatic test_order();
        ckpt_vals = {V61, V60}; timeout_cycles = 0;
        start = 1; cyc(); start = 0;
        ckpt_in = V61;
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if (ckpt_idx !== '0 || match_stb !== 1'b0) begin errors++; $display("FAIL out_of_order: idx=%0d want 0", ckpt_idx); end
        ckpt_in = V60; for (int i = 0; i < NEED; i++) cyc();
        ckpt_in = V61; for (int i = 0; i < NEED; i++) cyc();
        checks++;
        if (dut_vec !== mdl_vec() || pass !== 1'b1) begin errors++; $display("FAIL in_order: got %h want %h", dut_vec, mdl_vec()); end
        // Match and timeout on the same cycle: the final match lands on WAIT cycle 6 with limit 6.
        timeout_cycles = 6;
        start = 1; cyc(); start = 0;
        for (int j = 1; j <= 6; j++) begin
            ckpt_in = (j <= NEED) ? V60 : (j > 6 - NEED) ? V61 : 16'h0;
            cyc();
        end
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0 || elapsed !== TMO_W'(6)) begin
            errors++; $display("FAIL match_vs_timeout: pass=%b fail=%b el=%0d want 1/0/6", pass, fail, elapsed);
        end
        // Repeated value needs a separate match per checkpoint.
        ckpt_vals = {V60, V60}; timeout_cycles = 0; ckpt_in = V60;
        start = 1; cyc(); start = 0;
        for (int i = 0; i < NEED; i++) cyc();
        checks++;
        if (ckpt_idx !== IDX_W'(1) || pass !== 1'b0) begin errors++; $display("FAIL repeat_first: idx=%0d pass=%b want 1/0", ckpt_idx, pass); end
        for (int i = 0; i < NEED; i++) cyc();
        checks++;
        if (dut_vec !== mdl_vec() || pass !== 1'b1) begin errors++; $display("FAIL repeat_second: got %h want %h", dut_vec, mdl_vec()); end
    endtask

    task automatic test_rearm();
        ckpt_vals = {V61, V60}; timeout_cycles = 0; ckpt_in = V60;
        start = 1; clear = 1; cyc(); clear = 0; start = 0;
        checks++;
        if (busy !== 1'b1 || dut_vec !== mdl_vec()) begin errors++; $display("FAIL start_over_clear: got %h want %h", dut_vec, mdl_vec()); end
        for (int i = 0; i < NEED; i++) cyc();
        ckpt_in = '0; start = 1; clear = 1; cyc(); start = 0; clear = 0;
        checks++;
        if (ckpt_idx !== IDX_W'(1) || busy !== 1'b1 || elapsed !== TMO_W'(NEED + 1)) begin
            errors++; $display("FAIL start_in_wait: idx=%0d el=%0d busy=%b want 1/%0d/1", ckpt_idx, elapsed, busy, NEED + 1);
        end
        ckpt_in = V61; wb_rst_i = 1; cyc(); wb_rst_i = 0;
        checks++;
        if (dut_vec !== '0) begin errors++; $display("FAIL reset_mid_wait: got %h want 0", dut_vec); end
        cyc();
        checks++;
        if (dut_vec !== '0) begin errors++; $display("FAIL idle_after_reset: got %h want 0", dut_vec); end
    endtask

    task automatic test_saturate();
        ckpt_in = '0; timeout_cycles = 0;
        start = 1; cyc(); start = 0;
        for (int i = 0; i < MAX_EL + 10; i++) cyc();
        checks++;
        if (elapsed !== TMO_W'(MAX_EL) || busy !== 1'b1 || dut_vec !== mdl_vec()) begin
            errors++; $display("FAIL saturate: el=%0d busy=%b want %0d/1", elapsed, busy, MAX_EL);
        end
        wb_rst_i = 1; cyc(); wb_rst_i = 0;
    endtask

    task automatic test_random();
        logic [15:0] prev;
        prev = '0;
        for (int i = 0; i < 3000; i++) begin
            wb_rst_i = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 19) == 0);
            clear    = ($urandom_range(0, 9) == 0);
            if (start) begin
                for (int k = 0; k < NUM_CKPT; k++)
                    ckpt_vals[k*WIDTH +: WIDTH] = $urandom_range(0, 1) ? V61 : V60;
                timeout_cycles = ($urandom_range(0, 3) == 0) ? '0 : TMO_W'($urandom_range(1, 40));
            end
            case ($urandom_range(0, 3))
                0: ckpt_in = V60;
                1: ckpt_in = V61;
                2: ckpt_in = 16'($urandom);
                default: ckpt_in = prev;
            endcase
            prev = ckpt_in;
            cyc();
            checks++;
            if (dut_vec !== mdl_vec()) begin errors++; $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, mdl_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_order();
        test_rearm();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mprj_checkpoint_monitor.md
MPRJ_CHECKPOINT_MONITOR -- requirements
Module: mprj_checkpoint_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the monitored checkpoint bus.
REQ-002 SHALL have parameter NUM_CKPT, default 2, range 1-16: number of checkpoints in the ordered sequence.
REQ-003 SHALL have parameter TMO_W, default 24: width of the timeout and elapsed counters.
REQ-004 SHALL have port wb_clk_i, input, 1: single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port wb_rst_i, input, 1: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that arms a run.
REQ-007 SHALL have port clear, input, 1: returns a finished run to IDLE.
REQ-008 SHALL have port ckpt_in, input, WIDTH: monitored value, e.g. the mprj_io[31:16] checkbits.
REQ-009 SHALL have port ckpt_vals, input, NUM_CKPT*WIDTH: expected values; checkpoint k is in slice [k*WIDTH +: WIDTH].
REQ-010 SHALL have port timeout_cycles, input, TMO_W: run limit in cycles; 0 disables the timeout.
REQ-011 SHALL have port busy, output, 1: high in WAIT.
REQ-012 SHALL have port pass, output, 1: high in PASS.
REQ-013 SHALL have port fail, output, 1: high in FAIL.
REQ-014 SHALL have port ckpt_idx, output, clog2(NUM_CKPT+1): number of checkpoints matched so far.
REQ-015 SHALL have port match_stb, output, 1: one-cycle pulse on each checkpoint match.
REQ-016 SHALL have port elapsed, output, TMO_W: cycles spent in WAIT; saturates at all-ones.

Function
REQ-017 SHALL implement the states IDLE, WAIT, PASS and FAIL; every output SHALL be registered.
REQ-018 SHALL move IDLE->WAIT on start; at the same edge ckpt_idx and elapsed SHALL be cleared to 0.
REQ-019 SHALL, in WAIT, compare ckpt_in against checkpoint ckpt_idx only; values of later checkpoints SHALL be ignored until their turn.
REQ-020 SHALL, on a match, pulse match_stb on the next cycle and increment ckpt_idx.
REQ-021 SHALL enter PASS at the edge that increments ckpt_idx to NUM_CKPT.
REQ-022 SHALL increment elapsed each WAIT cycle; elapsed SHALL hold its value in PASS and FAIL.
REQ-023 SHALL enter FAIL when timeout_cycles != 0 and elapsed+1 == timeout_cycles with no match in that cycle.
REQ-024 SHALL give priority to the match when a match and the timeout fall in the same cycle.
REQ-025 SHALL ignore start while in WAIT.
REQ-026 SHALL restart a run on start in PASS or FAIL, as from IDLE.
REQ-027 SHALL move PASS or FAIL -> IDLE on clear; clear SHALL be ignored in IDLE and WAIT.
REQ-028 SHALL give start priority when start and clear are asserted together.
REQ-029 SHALL allow consecutive identical checkpoint values; each one SHALL require a separate matching cycle, at one match per cycle at most.

Reset
REQ-030 SHALL, while wb_rst_i is high at a clock edge, set state to IDLE and ckpt_idx, elapsed, busy, pass, fail and match_stb to 0.
REQ-031 SHALL abort a run in progress when reset is asserted mid-run, without pulsing match_stb.

Configuration
REQ-032 SHALL implement macro CKPT_DEGLITCH_EN: when defined, a match requires ckpt_in equal to the expected value on 2 consecutive WAIT cycles; this adds one cycle of latency, and the qualifier SHALL be cleared on start, on reset and after each match.
REQ-033 SHALL match on a single cycle of equality when CKPT_DEGLITCH_EN is undefined.

Verification
REQ-034 Basic sequence: NUM_CKPT=2, vals {AB60,AB61}, timeout 1000, start, drive AB60 at cycle 5 and AB61 at cycle 9 -> two match_stb pulses, pass=1, ckpt_idx=2.
REQ-035 Timeout: timeout 50, ckpt_in held at 0000 -> fail=1 after exactly 50 WAIT cycles, elapsed=50, ckpt_idx=0.
REQ-036 Out-of-order and boundary: drive AB61 before AB60 -> no match for AB61; match and timeout in the same cycle -> pass=1.
REQ-037 Reset and re-arm: wb_rst_i mid-WAIT -> all outputs 0 and state IDLE; start during WAIT ignored; start in FAIL restarts with elapsed=0.
REQ-038 With CKPT_DEGLITCH_EN: a 1-cycle AB60 glitch -> no match; AB60 held 2 cycles -> match_stb one cycle later than in the undefined build.
